// File: rtl/serial2parallel_if.sv
// serial2parallel_if
//   Bundles the serial input stream, the parallel output handshake, the sticky
//   status flags and the bit counter of the serial2parallel deserializer.
//   Port summary:
//     serial_i, valid_i, last_i : serial bit stream from the upstream serializer
//     out_data_o, out_valid_o   : assembled word and its valid flag
//     out_ready_i               : consumer accepts the held word
//     frame_err_o, overflow_o   : sticky error flags
//     clear_i                   : synchronous clear of the sticky flags
//     bit_cnt_o                 : bits collected in the current word
//   Modports: master = stream source / consumer side, slave = deserializer.
interface serial2parallel_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             serial_i;
  logic             valid_i;
  logic             last_i;
  logic [WIDTH-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             frame_err_o;
  logic             overflow_o;
  logic             clear_i;
  logic [CNT_W-1:0] bit_cnt_o;

  modport master (
    output serial_i, valid_i, last_i, out_ready_i, clear_i,
    input  out_data_o, out_valid_o, frame_err_o, overflow_o, bit_cnt_o
  );

  modport slave (
    input  serial_i, valid_i, last_i, out_ready_i, clear_i,
    output out_data_o, out_valid_o, frame_err_o, overflow_o, bit_cnt_o
  );
endinterface

// File: rtl/serial2parallel.sv
// serial2parallel
//   Reassembles WIDTH-bit words from an LSB-first serial stream and presents
//   each completed word on a single-entry valid/ready holding register.
//   Framing errors (missing or early last_i) and words dropped because the
//   holding register was still occupied are reported on sticky flags.
//   Ports:
//     clk      : rising-edge clock
//     reset_n  : asynchronous active-low reset
//     bus      : serial2parallel_if slave modport (stream in, word out, flags)
module serial2parallel #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  serial2parallel_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  // Bit-collection phase, derived from the bit counter rather than stored.
  typedef enum logic {
    COLLECT,
    LAST_BIT
  } phase_t;

  phase_t           phase;

  // Only the first WIDTH-1 bits need storage; the final bit is taken
  // straight from serial_i when the word completes.
  logic [WIDTH-2:0] shreg_reg;
  logic [WIDTH-2:0] shreg_next;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [CNT_W-1:0] bit_cnt_next;
  logic [WIDTH-1:0] out_data_reg;
  logic [WIDTH-1:0] out_data_next;
  logic             out_valid_reg;
  logic             out_valid_next;
  logic             frame_err_reg;
  logic             frame_err_next;
  logic             overflow_reg;
  logic             overflow_next;

  logic             word_done;
  logic             early_last;
  logic             out_free;
  logic             frame_set;
  logic             overflow_set;
  logic [WIDTH-1:0] word;

  // Each storage bit captures serial_i only when the counter points at it.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shreg
      assign shreg_next[gi] = (bus.valid_i && (bit_cnt_reg == CNT_W'(gi)))
                              ? bus.serial_i : shreg_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_reg     <= '0;
      bit_cnt_reg   <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      shreg_reg     <= shreg_next;
      bit_cnt_reg   <= bit_cnt_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      frame_err_reg <= frame_err_next;
      overflow_reg  <= overflow_next;
    end
  end

  always_comb begin
    phase          = (bit_cnt_reg == LAST_IDX) ? LAST_BIT : COLLECT;
    word_done      = 1'b0;
    early_last     = 1'b0;
    word           = {bus.serial_i, shreg_reg};
    bit_cnt_next   = bit_cnt_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;

    // A held word leaving on this edge frees the register for a new one.
    out_free = !out_valid_reg || bus.out_ready_i;

    if (bus.valid_i) begin
      case (phase)
        LAST_BIT: begin
          word_done    = 1'b1;
          bit_cnt_next = '0;
        end
        default: begin
          if (bus.last_i) begin
            // Word ended short: drop the partial bits and restart.
            early_last   = 1'b1;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          end
        end
      endcase
    end

    if (word_done && out_free) begin
      out_data_next  = word;
      out_valid_next = 1'b1;
    end else if (out_valid_reg && bus.out_ready_i) begin
      out_valid_next = 1'b0;
    end

    frame_set    = (word_done && !bus.last_i) || early_last;
    overflow_set = word_done && !out_free;

    // Setting takes priority over a simultaneous clear.
    frame_err_next = frame_set    ? 1'b1 : (bus.clear_i ? 1'b0 : frame_err_reg);
    overflow_next  = overflow_set ? 1'b1 : (bus.clear_i ? 1'b0 : overflow_reg);
  end

  assign bus.out_data_o  = out_data_reg;
  assign bus.out_valid_o = out_valid_reg;
  assign bus.frame_err_o = frame_err_reg;
  assign bus.overflow_o  = overflow_reg;
  assign bus.bit_cnt_o   = bit_cnt_reg;
endmodule

// File: tb/tb_serial2parallel.sv
// tb_serial2parallel
//   Directed scenarios plus a randomized run for serial2parallel (WIDTH=4),
//   checked against a queue-based reference model of the word assembly,
//   holding register and sticky flags.
module tb_serial2parallel;
  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  serial2parallel_if #(.WIDTH(WIDTH)) bus();

  serial2parallel #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  bit               m_bits[$];
  logic [WIDTH-1:0] m_data;
  bit               m_valid;
  bit               m_ferr;
  bit               m_ovf;

  task automatic model_reset();
    m_bits.delete();
    m_data  = '0;
    m_valid = 0;
    m_ferr  = 0;
    m_ovf   = 0;
  endtask

  // Applies one clock edge worth of behaviour using the currently driven inputs.
  task automatic model_edge();
    bit               done;
    bit               early;
    bit               free;
    bit               set_f;
    bit               set_o;
    logic [WIDTH-1:0] w;
    done  = 0;
    early = 0;
    w     = '0;
    free  = !m_valid || bus.out_ready_i;
    if (bus.valid_i) begin
      m_bits.push_back(bus.serial_i);
      if (m_bits.size() == WIDTH) begin
        done = 1;
        for (int i = 0; i < WIDTH; i++) w[i] = m_bits[i];
        m_bits.delete();
      end else if (bus.last_i) begin
        early = 1;
        m_bits.delete();
      end
    end
    set_f = (done && !bus.last_i) || early;
    set_o = done && !free;
    if (done && free) begin
      m_data  = w;
      m_valid = 1;
    end else if (m_valid && bus.out_ready_i) begin
      m_valid = 0;
    end
    m_ferr = set_f ? 1'b1 : (bus.clear_i ? 1'b0 : m_ferr);
    m_ovf  = set_o ? 1'b1 : (bus.clear_i ? 1'b0 : m_ovf);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input bit last);
    bus.serial_i = b;
    bus.valid_i  = 1'b1;
    bus.last_i   = last;
    tick();
    bus.valid_i  = 1'b0;
    bus.last_i   = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input bit with_last);
    for (int i = 0; i < WIDTH; i++) send_bit(w[i], with_last && (i == WIDTH - 1));
  endtask

  task automatic clear_flags();
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
  endtask

  task automatic test_reset();
    bus.serial_i = 0; bus.valid_i = 0; bus.last_i = 0;
    bus.out_ready_i = 0; bus.clear_i = 0;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_data_o !== 4'h0 || bus.out_valid_o !== 1'b0 || bus.bit_cnt_o !== 2'd0 ||
        bus.frame_err_o !== 1'b0 || bus.overflow_o !== 1'b0)
      $display("FAIL reset_state: data=%h valid=%b cnt=%0d ferr=%b ovf=%b, required all zero",
               bus.out_data_o, bus.out_valid_o, bus.bit_cnt_o, bus.frame_err_o, bus.overflow_o);
    else n_pass++;
    reset_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bus.out_ready_i = 1'b1;
    send_word(4'hB, 1'b1);
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'hB)
      $display("FAIL basic_word: valid=%b data=%h, required valid=1 data=b", bus.out_valid_o, bus.out_data_o);
    else n_pass++;
    n_checks++;
    if (bus.frame_err_o !== 1'b0 || bus.overflow_o !== 1'b0)
      $display("FAIL basic_flags: ferr=%b ovf=%b, required 0 0", bus.frame_err_o, bus.overflow_o);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid_o !== 1'b0)
      $display("FAIL basic_one_cycle: valid=%b, required 0", bus.out_valid_o);
    else n_pass++;
    $display("test_basic done");
  endtask

  task automatic test_gaps();
    logic [WIDTH-1:0] w;
    logic [1:0]       exp_cnt;
    w = 4'hB;
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      send_bit(w[i], i == WIDTH - 1);
      exp_cnt = 2'((i + 1) % WIDTH);
      n_checks++;
      if (bus.bit_cnt_o !== exp_cnt)
        $display("FAIL gaps_bit_cnt[%0d]: got %0d, required %0d", i, bus.bit_cnt_o, exp_cnt);
      else n_pass++;
      if (i != WIDTH - 1) repeat (3) tick();
    end
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'hB)
      $display("FAIL gaps_word: valid=%b data=%h, required valid=1 data=b", bus.out_valid_o, bus.out_data_o);
    else n_pass++;
    bus.out_ready_i = 1'b1;
    tick();
    $display("test_gaps done");
  endtask

  task automatic test_overflow();
    bus.out_ready_i = 1'b0;
    send_word(4'h5, 1'b1);
    send_word(4'hA, 1'b1);
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'h5)
      $display("FAIL ovf_hold: valid=%b data=%h, required valid=1 data=5", bus.out_valid_o, bus.out_data_o);
    else n_pass++;
    n_checks++;
    if (bus.overflow_o !== 1'b1)
      $display("FAIL ovf_flag: got %b, required 1", bus.overflow_o);
    else n_pass++;
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    n_checks++;
    if (bus.out_valid_o !== 1'b0)
      $display("FAIL ovf_drain: valid=%b data=%h, required valid=0", bus.out_valid_o, bus.out_data_o);
    else n_pass++;
    clear_flags();
    n_checks++;
    if (bus.overflow_o !== 1'b0)
      $display("FAIL ovf_clear: got %b, required 0", bus.overflow_o);
    else n_pass++;
    $display("test_overflow done");
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] w;
    w = 4'hC;
    bus.out_ready_i = 1'b0;
    send_word(4'h3, 1'b1);
    n_checks++;
    if (bus.out_data_o !== 4'h3 || bus.out_valid_o !== 1'b1)
      $display("FAIL b2b_first: valid=%b data=%h, required valid=1 data=3", bus.out_valid_o, bus.out_data_o);
    else n_pass++;
    for (int i = 0; i < WIDTH - 1; i++) send_bit(w[i], 1'b0);
    bus.out_ready_i = 1'b1;
    send_bit(w[WIDTH-1], 1'b1);
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'hC)
      $display("FAIL b2b_second: valid=%b data=%h, required valid=1 data=c", bus.out_valid_o, bus.out_data_o);
    else n_pass++;
    n_checks++;
    if (bus.overflow_o !== 1'b0)
      $display("FAIL b2b_ovf: got %b, required 0", bus.overflow_o);
    else n_pass++;
    tick();
    $display("test_back_to_back done");
  endtask

  task automatic test_early_last();
    bus.out_ready_i = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    n_checks++;
    if (bus.frame_err_o !== 1'b1 || bus.bit_cnt_o !== 2'd0 || bus.out_valid_o !== 1'b0)
      $display("FAIL early_last: ferr=%b cnt=%0d valid=%b, required 1 0 0",
               bus.frame_err_o, bus.bit_cnt_o, bus.out_valid_o);
    else n_pass++;
    clear_flags();
    send_word(4'h9, 1'b1);
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'h9 || bus.frame_err_o !== 1'b0)
      $display("FAIL early_recover: valid=%b data=%h ferr=%b, required 1 9 0",
               bus.out_valid_o, bus.out_data_o, bus.frame_err_o);
    else n_pass++;
    tick();
    $display("test_early_last done");
  endtask

  task automatic test_reset_midword();
    bus.out_ready_i = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.bit_cnt_o !== 2'd0 || bus.out_valid_o !== 1'b0)
      $display("FAIL midword_reset: cnt=%0d valid=%b, required 0 0", bus.bit_cnt_o, bus.out_valid_o);
    else n_pass++;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(4'h6, 1'b1);
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'h6)
      $display("FAIL midword_word: valid=%b data=%h, required valid=1 data=6", bus.out_valid_o, bus.out_data_o);
    else n_pass++;
    tick();
    send_word(4'h7, 1'b0);
    n_checks++;
    if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 4'h7 || bus.frame_err_o !== 1'b1)
      $display("FAIL no_last: valid=%b data=%h ferr=%b, required 1 7 1",
               bus.out_valid_o, bus.out_data_o, bus.frame_err_o);
    else n_pass++;
    tick();
    clear_flags();
    $display("test_reset_midword done");
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      bus.valid_i     = ($urandom_range(0, 9) < 6);
      bus.serial_i    = $urandom_range(0, 1);
      if (m_bits.size() == WIDTH - 1) bus.last_i = ($urandom_range(0, 9) != 0);
      else                            bus.last_i = ($urandom_range(0, 19) == 0);
      bus.out_ready_i = ($urandom_range(0, 9) < 5);
      bus.clear_i     = ($urandom_range(0, 14) == 0);
      tick();
      n_checks++;
      if (bus.out_valid_o !== m_valid || bus.out_data_o !== m_data ||
          bus.frame_err_o !== m_ferr || bus.overflow_o !== m_ovf ||
          bus.bit_cnt_o !== 2'(m_bits.size())) begin
        errs++;
        if (errs <= 10)
          $display("FAIL random[%0d]: valid=%b data=%h ferr=%b ovf=%b cnt=%0d, required %b %h %b %b %0d",
                   c, bus.out_valid_o, bus.out_data_o, bus.frame_err_o, bus.overflow_o, bus.bit_cnt_o,
                   m_valid, m_data, m_ferr, m_ovf, m_bits.size());
      end else n_pass++;
    end
    bus.valid_i = 0; bus.last_i = 0; bus.clear_i = 0;
    $display("test_random done: %0d cycles compared", 400);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overflow();
    test_back_to_back();
    test_early_last();
    test_reset_midword();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
